// File: rtl/riscv_tcm_loader.sv
// riscv_tcm_loader: packs a boot byte stream into 32-bit TCM writes and holds the core in reset until loaded.
// Define TCM_LOADER_VERIFY_EN to add a checksum readback pass before releasing the core.
module riscv_tcm_loader #(
  parameter logic [31:0] BASE_ADDR       = 32'h80000000,
  parameter int          MAX_BYTES       = 131072,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [31:0] mem_d_addr_o,
  output logic [31:0] mem_d_data_wr_o,
  output logic        mem_d_rd_o,
  output logic [3:0]  mem_d_wr_o,
  output logic        mem_d_cacheable_o,
  output logic [10:0] mem_d_req_tag_o,
  output logic        mem_d_invalidate_o,
  output logic        mem_d_writeback_o,
  output logic        mem_d_flush_o,
  input  logic        mem_d_accept_i,
  input  logic        mem_d_ack_i,
  input  logic        mem_d_error_i,
  input  logic [31:0] mem_d_data_rd_i,
  input  logic [10:0] mem_d_resp_tag_i,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o,
  output logic [17:0] byte_count_o
);
  typedef enum logic [2:0] {IDLE, FILL, REQ, DRAIN, VERIFY, DONE, ERROR} state_t;
  state_t      state;
  logic [31:0] addr, data, woff;
  logic [3:0]  strb;
  logic        last_q;
  logic [17:0] byte_cnt;
  logic [2:0]  out_cnt;
  logic [1:0]  lane;
  logic        can_issue, wr_fire, rd_live, rd_fire, in_fire, ack_dec, busy, ack_err, unused_ok;
  assign lane      = byte_cnt[1:0];
  assign can_issue = out_cnt < 3'(MAX_OUTSTANDING);
  assign wr_fire   = state == REQ && can_issue && mem_d_accept_i;
  assign rd_fire   = rd_live && mem_d_accept_i;
  assign in_fire   = in_valid_i && in_ready_o;
  assign ack_dec   = mem_d_ack_i && out_cnt != 3'd0;
  assign busy      = state == FILL || state == REQ || state == DRAIN || state == VERIFY;
  assign ack_err   = mem_d_ack_i && mem_d_error_i && busy;
  assign woff      = addr - BASE_ADDR;
  assign in_ready_o         = state == FILL;
  assign mem_d_wr_o         = (state == REQ && can_issue) ? strb : 4'h0;
  assign mem_d_rd_o         = rd_live;
  assign mem_d_addr_o       = addr;
  assign mem_d_data_wr_o    = data;
  assign mem_d_req_tag_o    = woff[12:2];
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;
  assign byte_count_o       = byte_cnt;
  assign unused_ok          = ^{mem_d_resp_tag_i, mem_d_data_rd_i, woff};
`ifdef TCM_LOADER_VERIFY_EN
  logic [31:0] sum_wr, sum_rd, rsp_mask;
  logic [15:0] n_words, rd_cnt, rsp_cnt;
  logic [3:0]  last_strb;
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  assign rd_live  = state == VERIFY && rd_cnt != n_words && can_issue;
  // responses return in order, so only the final word needs its partial strobe mask
  assign rsp_mask = (rsp_cnt == n_words - 16'd1) ? lane_mask(last_strb) : 32'hFFFF_FFFF;
`else
  assign rd_live  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_cnt <= 3'd0;
    else out_cnt <= out_cnt + {2'b0, wr_fire | rd_fire} - {2'b0, ack_dec};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= BASE_ADDR;
      data       <= '0;
      strb       <= '0;
      last_q     <= 1'b0;
      byte_cnt   <= '0;
      core_rst_o <= 1'b1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
`ifdef TCM_LOADER_VERIFY_EN
      sum_wr     <= '0;
      sum_rd     <= '0;
      n_words    <= '0;
      rd_cnt     <= '0;
      rsp_cnt    <= '0;
      last_strb  <= '0;
`endif
    end else if (ack_err) begin
      state   <= ERROR;
      error_o <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start_i) begin
          state      <= FILL;
          addr       <= BASE_ADDR;
          data       <= '0;
          strb       <= '0;
          last_q     <= 1'b0;
          byte_cnt   <= '0;
          core_rst_o <= 1'b1;
          done_o     <= 1'b0;
          error_o    <= 1'b0;
`ifdef TCM_LOADER_VERIFY_EN
          sum_wr     <= '0;
          n_words    <= '0;
`endif
        end
        FILL: if (in_fire) begin
          if (byte_cnt == 18'(MAX_BYTES)) begin
            state   <= ERROR;
            error_o <= 1'b1;
          end else begin
            data[{lane, 3'b000} +: 8] <= in_data_i;
            strb[lane] <= 1'b1;
            byte_cnt   <= byte_cnt + 18'd1;
            last_q     <= in_last_i;
            if (lane == 2'd3 || in_last_i) state <= REQ;
          end
        end
        REQ: if (wr_fire) begin
          addr  <= addr + 32'd4;
          data  <= '0;
          strb  <= '0;
          state <= last_q ? DRAIN : FILL;
`ifdef TCM_LOADER_VERIFY_EN
          sum_wr    <= sum_wr + (data & lane_mask(strb));
          n_words   <= n_words + 16'd1;
          last_strb <= strb;
`endif
        end
        DRAIN: if (out_cnt == 3'd0) begin
`ifdef TCM_LOADER_VERIFY_EN
          state   <= VERIFY;
          addr    <= BASE_ADDR;
          rd_cnt  <= '0;
          rsp_cnt <= '0;
          sum_rd  <= '0;
`else
          state      <= DONE;
          done_o     <= 1'b1;
          core_rst_o <= 1'b0;
`endif
        end
`ifdef TCM_LOADER_VERIFY_EN
        VERIFY: begin
          if (rd_fire) begin
            addr   <= addr + 32'd4;
            rd_cnt <= rd_cnt + 16'd1;
          end
          if (ack_dec) begin
            sum_rd  <= sum_rd + (mem_d_data_rd_i & rsp_mask);
            rsp_cnt <= rsp_cnt + 16'd1;
          end
          if (rsp_cnt == n_words) begin
            state      <= (sum_rd == sum_wr) ? DONE : ERROR;
            done_o     <= sum_rd == sum_wr;
            error_o    <= sum_rd != sum_wr;
            core_rst_o <= sum_rd != sum_wr;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_tcm_loader.sv
// tb_riscv_tcm_loader: random byte images against a word-packing reference model with a bus responder.
module tb_riscv_tcm_loader;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int MAXB = 64;
  localparam int MAXO = 2;
  logic clk = 0, rst = 0, start_i = 0, in_valid_i = 0, in_last_i = 0;
  logic [7:0] in_data_i = 0;
  logic in_ready_o, mem_d_rd_o, mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o;
  logic core_rst_o, done_o, error_o;
  logic [31:0] mem_d_addr_o, mem_d_data_wr_o;
  logic [3:0] mem_d_wr_o;
  logic [10:0] mem_d_req_tag_o;
  logic [17:0] byte_count_o;
  logic mem_d_accept_i = 0, mem_d_ack_i = 0, mem_d_error_i = 0;
  logic [31:0] mem_d_data_rd_i = 0;
  logic [10:0] mem_d_resp_tag_i = 0;
  riscv_tcm_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_last_i(in_last_i), .in_ready_o(in_ready_o), .mem_d_addr_o(mem_d_addr_o),
    .mem_d_data_wr_o(mem_d_data_wr_o), .mem_d_rd_o(mem_d_rd_o), .mem_d_wr_o(mem_d_wr_o),
    .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_invalidate_o(mem_d_invalidate_o), .mem_d_writeback_o(mem_d_writeback_o),
    .mem_d_flush_o(mem_d_flush_o), .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
    .mem_d_error_i(mem_d_error_i), .mem_d_data_rd_i(mem_d_data_rd_i),
    .mem_d_resp_tag_i(mem_d_resp_tag_i), .core_rst_o(core_rst_o), .done_o(done_o),
    .error_o(error_o), .byte_count_o(byte_count_o));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [10:0] tag;} wr_t;
  wr_t wlog[$];
  int due_q[$];
  bit isrd_q[$];
  logic [31:0] radr_q[$];
  logic [31:0] mem [64];
  int checks = 0, failures = 0, cyc = 0, hold_cnt = 0, rand_acc = 0, dmin = 1, dmax = 1;
  int err_at = -1, ack_idx = 0, mod_out = 0, max_out = 0, rd_idx = 0, corrupt_at = -1;
  bit prev_pend = 0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0] prev_strb;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // responder: accepts, queues in-order acks with a delay, mirrors writes into a word memory
  always @(negedge clk) begin
    bit pres, a, k;
    logic [31:0] w;
    cyc++;
    if (!rst) begin
      due_q.delete(); isrd_q.delete(); radr_q.delete();
      mod_out = 0; prev_pend = 0;
      mem_d_accept_i = 0; mem_d_ack_i = 0; mem_d_error_i = 0;
    end else begin
      pres = (mem_d_wr_o != 4'h0) || mem_d_rd_o;
      k = due_q.size() > 0 && due_q[0] <= cyc;
      if (pres) begin
        check("issue_below_max", 32'(mod_out < MAXO), 1);
        check("no_byte_in_req", 32'(in_ready_o), 0);
        if (prev_pend) begin
          check("hold_addr", mem_d_addr_o, prev_addr);
          check("hold_data", mem_d_data_wr_o, prev_data);
          check("hold_strb", 32'(mem_d_wr_o), 32'(prev_strb));
        end
      end
      a = pres && hold_cnt == 0 && (rand_acc == 0 || $urandom_range(0, 1) == 1);
      if (pres && hold_cnt > 0) hold_cnt--;
      mem_d_accept_i = a;
      mem_d_ack_i = k;
      mem_d_error_i = k && ack_idx == err_at;
      mem_d_data_rd_i = 0;
      if (k) begin
        if (isrd_q[0]) begin
          w = radr_q[0];
          mem_d_data_rd_i = mem[w[7:2]] ^ ((rd_idx == corrupt_at) ? 32'h10 : 32'h0);
          rd_idx++;
        end
        void'(due_q.pop_front()); void'(isrd_q.pop_front()); void'(radr_q.pop_front());
        ack_idx++;
        mod_out--;
      end
      if (a) begin
        due_q.push_back(cyc + $urandom_range(dmin, dmax));
        isrd_q.push_back(mem_d_rd_o);
        radr_q.push_back(mem_d_addr_o);
        mod_out++;
        if (mem_d_wr_o != 4'h0) begin
          wlog.push_back('{mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_req_tag_o});
          w = mem_d_addr_o;
          for (int j = 0; j < 4; j++) if (mem_d_wr_o[j]) mem[w[7:2]][8*j +: 8] = mem_d_data_wr_o[8*j +: 8];
        end
      end
      if (mod_out > max_out) max_out = mod_out;
      prev_pend = pres && !a;
      prev_addr = mem_d_addr_o;
      prev_data = mem_d_data_wr_o;
      prev_strb = mem_d_wr_o;
    end
  end
  task automatic start_load();
    ack_idx = 0;
    rd_idx = 0;
    wlog.delete();
    @(negedge clk) start_i = 1;
    @(negedge clk) start_i = 0;
  endtask
  task automatic send(input logic [7:0] q[$], input bit use_last, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      int t;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      in_valid_i = 1;
      in_data_i = q[i];
      in_last_i = use_last && i == q.size() - 1;
      t = 0;
      while (!in_ready_o && t < 300) begin @(negedge clk); t++; end
      check("byte_taken", 32'(t < 300), 1);
      @(negedge clk);
      in_valid_i = 0;
      in_last_i = 0;
    end
  endtask
  task automatic wait_end();
    int t;
    t = 0;
    while (!(done_o || error_o) && t < 3000) begin @(negedge clk); t++; end
    check("load_finished", 32'(t < 3000), 1);
  endtask
  task automatic rand_img(output logic [7:0] q[$], input int n);
    q.delete();
    repeat (n) q.push_back(8'($urandom));
  endtask
  // model: byte i lands in word i/4, lane i%4; a word of m bytes has strobe (1<<m)-1
  task automatic check_image(input logic [7:0] q[$]);
    int n, nw, m;
    logic [31:0] d;
    n = q.size();
    nw = (n + 3) / 4;
    check("done", 32'(done_o), 1);
    check("error", 32'(error_o), 0);
    check("core_rst", 32'(core_rst_o), 0);
    check("byte_count", 32'(byte_count_o), 32'(n));
    check("n_writes", 32'(wlog.size()), 32'(nw));
    for (int k = 0; k < nw && k < wlog.size(); k++) begin
      m = (n - 4 * k > 4) ? 4 : n - 4 * k;
      d = 0;
      for (int j = 0; j < m; j++) d += 32'(q[4*k+j]) << (8 * j);
      check("wr_addr", wlog[k].addr, BASE + 32'(4 * k));
      check("wr_data", wlog[k].data, d);
      check("wr_strb", 32'(wlog[k].strb), 32'((1 << m) - 1));
      check("wr_tag", 32'(wlog[k].tag), 32'(k));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] q[$];
    int n;
    repeat (3) @(negedge clk);
    check("rst_core_rst", 32'(core_rst_o), 1);
    check("rst_in_ready", 32'(in_ready_o), 0);
    check("rst_wr", 32'(mem_d_wr_o), 0);
    check("rst_rd", 32'(mem_d_rd_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_byte_count", 32'(byte_count_o), 0);
    check("rst_addr", mem_d_addr_o, BASE);
    check("rst_tied", 32'({mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o}), 0);
    rst = 1;
    @(negedge clk);
    check("idle_core_rst", 32'(core_rst_o), 1);
    check("idle_in_ready", 32'(in_ready_o), 0);
    q = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h01, 8'h23};
    start_load();
    send(q, 1, 0);
    wait_end();
    check_image(q);
    hold_cnt = 5;
    rand_img(q, 8);
    start_load();
    send(q, 1, 1);
    wait_end();
    check_image(q);
    dmin = 10; dmax = 10; max_out = 0;
    rand_img(q, 16);
    start_load();
    send(q, 1, 0);
    wait_end();
    check_image(q);
    check("max_outstanding", 32'(max_out), MAXO);
    dmin = 3; dmax = 3; err_at = 1;
    rand_img(q, 8);
    start_load();
    send(q, 1, 0);
    wait_end();
    check("err_error", 32'(error_o), 1);
    check("err_done", 32'(done_o), 0);
    check("err_core_rst", 32'(core_rst_o), 1);
    n = wlog.size();
    repeat (20) @(negedge clk);
    check("err_no_new_writes", 32'(wlog.size()), 32'(n));
    err_at = -1;
    rand_img(q, 8);
    start_load();
    check("restart_error_cleared", 32'(error_o), 0);
    check("restart_core_rst", 32'(core_rst_o), 1);
    send(q, 1, 0);
    wait_end();
    check_image(q);
    q = '{8'hA5};
    start_load();
    send(q, 1, 0);
    wait_end();
    check_image(q);
    rand_acc = 1; dmin = 1; dmax = 6;
    for (int r = 0; r < 6; r++) begin
      rand_img(q, $urandom_range(1, 40));
      start_load();
      send(q, 1, 2);
      wait_end();
      check_image(q);
    end
    rand_img(q, MAXB);
    start_load();
    send(q, 1, 0);
    wait_end();
    check_image(q);
    rand_img(q, MAXB + 1);
    start_load();
    send(q, 0, 0);
    wait_end();
    check("ovf_error", 32'(error_o), 1);
    check("ovf_done", 32'(done_o), 0);
    check("ovf_core_rst", 32'(core_rst_o), 1);
    check("ovf_byte_count", 32'(byte_count_o), MAXB);
    check("ovf_writes", 32'(wlog.size()), MAXB / 4);
    rand_acc = 0; dmin = 2; dmax = 2; hold_cnt = 1000;
    rand_img(q, 3);
    start_load();
    send(q, 1, 0);
    check("req_presented", 32'(mem_d_wr_o), 32'h7);
    #2 rst = 0;
    #1;
    check("arst_wr", 32'(mem_d_wr_o), 0);
    check("arst_core_rst", 32'(core_rst_o), 1);
    check("arst_in_ready", 32'(in_ready_o), 0);
    check("arst_byte_count", 32'(byte_count_o), 0);
    hold_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("post_arst_in_ready", 32'(in_ready_o), 0);
    check("post_arst_addr", mem_d_addr_o, BASE);
    check("post_arst_done", 32'(done_o), 0);
    rand_img(q, 10);
    start_load();
    send(q, 1, 1);
    wait_end();
    check_image(q);
`ifdef TCM_LOADER_VERIFY_EN
    rand_acc = 1; dmin = 1; dmax = 4;
    rand_img(q, 20);
    start_load();
    send(q, 1, 0);
    wait_end();
    check_image(q);
    corrupt_at = 2;
    rand_img(q, 20);
    start_load();
    send(q, 1, 0);
    wait_end();
    check("vfy_error", 32'(error_o), 1);
    check("vfy_done", 32'(done_o), 0);
    check("vfy_core_rst", 32'(core_rst_o), 1);
    corrupt_at = -1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
